// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// The counter operation encoding is shared by table entries and statistics counters.
package branch_predictor_pkg;

   localparam int BP_MODE_STATIC  = 0;
   localparam int BP_MODE_BIMODAL = 1;

   localparam int BP_CTR_W = 2;
   typedef logic [BP_CTR_W-1:0] ctr_t;

   typedef enum logic [1:0] {
      CTR_HOLD = 2'd0,
      CTR_INC  = 2'd1,
      CTR_DEC  = 2'd2
   } ctr_op_e;

   // Maps an enable plus a direction onto a counter operation.
   function automatic ctr_op_e ctr_op(input logic en, input logic up);
      if (!en)
         return CTR_HOLD;
      else if (up)
         return CTR_INC;
      else
         return CTR_DEC;
   endfunction

endpackage

// File: rtl/branch_predictor_sat.sv
// Combinational saturating counter step: next value for hold, increment or decrement.
// Increments stop at all-ones and decrements stop at zero; nothing ever wraps.
module sat_counter
   import branch_predictor_pkg::*;
#(
   parameter int W = 2
) (
   input  logic [W-1:0] cur,
   input  ctr_op_e      op,
   output logic [W-1:0] nxt
);

   always_comb begin
      nxt = cur;
      case (op)
         CTR_INC: if (cur != {W{1'b1}}) nxt = cur + W'(1);
         CTR_DEC: if (cur != {W{1'b0}}) nxt = cur - W'(1);
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, zero-latency lookup for fetch,
// EX-stage training with mispredict detection, and saturating lookup/mispredict statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int WORD_W  = 32,
   parameter int CTR_W   = 2,
   parameter int MODE    = 1,
   parameter int CNT_W   = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              lookup_en,
   input  logic [WORD_W-1:0] lookup_pc,
   output logic              pred_taken,
   output logic [WORD_W-1:0] pred_target,
   input  logic              update_en,
   input  logic [WORD_W-1:0] update_pc,
   input  logic              update_taken,
   input  logic [WORD_W-1:0] update_target,
   input  logic              update_pred_taken,
   input  logic [WORD_W-1:0] update_pred_target,
   input  logic              flush_all,
   output logic              mispredict,
   output logic [CNT_W-1:0]  lookup_cnt,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = WORD_W - IDX_W - 2;

   typedef logic [CTR_W-1:0] entry_ctr_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [WORD_W-1:0] target;
      entry_ctr_t        ctr;
   } btb_entry_t;

   // Weakly not-taken is 01..1 (MSB clear); weakly taken is 10..0 (MSB set).
   localparam entry_ctr_t CTR_WEAK_NT = entry_ctr_t'((1 << (CTR_W - 1)) - 1);
   localparam entry_ctr_t CTR_WEAK_T  = entry_ctr_t'(1 << (CTR_W - 1));

   btb_entry_t tbl [ENTRIES];

   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;
   btb_entry_t       l_ent;
   logic             l_hit;

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   entry_ctr_t       u_ctr_cur;
   entry_ctr_t       u_ctr_nxt;

   logic [CNT_W-1:0] lookup_cnt_nxt;
   logic [CNT_W-1:0] mispredict_cnt_nxt;

   logic unused_pc_low;
   assign unused_pc_low = &{1'b0, lookup_pc[1:0], update_pc[1:0]};

   // Lookup path: reads the table as it stands before this cycle's edge, no bypass.
   assign l_idx = lookup_pc[IDX_W+1:2];
   assign l_tag = lookup_pc[WORD_W-1:IDX_W+2];
   assign l_ent = tbl[l_idx];
   assign l_hit = l_ent.valid && (l_ent.tag == l_tag);

   assign pred_taken  = (MODE == BP_MODE_BIMODAL) && l_hit && l_ent.ctr[CTR_W-1];
   assign pred_target = pred_taken ? l_ent.target : lookup_pc + WORD_W'(4);

   // update_en is a single-cycle strobe with no back-pressure: every field of the
   // resolved branch is valid exactly in the cycle update_en is high.
   assign u_idx     = update_pc[IDX_W+1:2];
   assign u_tag     = update_pc[WORD_W-1:IDX_W+2];
   assign u_hit     = tbl[u_idx].valid && (tbl[u_idx].tag == u_tag);
   assign u_ctr_cur = tbl[u_idx].ctr;

   assign mispredict = update_en &&
                       ((update_taken != update_pred_taken) ||
                        (update_taken && (update_pred_target != update_target)));

   sat_counter #(.W(CTR_W)) u_entry_ctr (
      .cur (u_ctr_cur),
      .op  (ctr_op(1'b1, update_taken)),
      .nxt (u_ctr_nxt)
   );

   sat_counter #(.W(CNT_W)) u_lookup_cnt (
      .cur (lookup_cnt),
      .op  (ctr_op(lookup_en, 1'b1)),
      .nxt (lookup_cnt_nxt)
   );

   sat_counter #(.W(CNT_W)) u_mispredict_cnt (
      .cur (mispredict_cnt),
      .op  (ctr_op(mispredict, 1'b1)),
      .nxt (mispredict_cnt_nxt)
   );

   // A flush wins over a same-cycle update; reset wins over both.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
         end
      end else if (flush_all) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid <= 1'b0;
         end
      end else if (update_en) begin
         if (u_hit) begin
            tbl[u_idx].ctr <= u_ctr_nxt;
            if (update_taken) tbl[u_idx].target <= update_target;
         end else if (update_taken) begin
            tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: update_target, ctr: CTR_WEAK_T};
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         lookup_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         lookup_cnt     <= lookup_cnt_nxt;
         mispredict_cnt <= mispredict_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor: a bimodal 32-bit-counter build and a
// static 4-bit-counter build share stimulus and are checked against one behavioural model.
module tb_branch_predictor;

   localparam int ENT    = 16;
   localparam int WORD_W = 32;
   localparam int CTR_MAX = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              lookup_en;
   logic [WORD_W-1:0] lookup_pc;
   logic              update_en;
   logic [WORD_W-1:0] update_pc;
   logic              update_taken;
   logic [WORD_W-1:0] update_target;
   logic              update_pred_taken;
   logic [WORD_W-1:0] update_pred_target;
   logic              flush_all;

   logic              pred_taken, pred_taken_s;
   logic [WORD_W-1:0] pred_target, pred_target_s;
   logic              mispredict, mispredict_s;
   logic [31:0]       lookup_cnt, mispredict_cnt;
   logic [3:0]        lookup_cnt_s, mispredict_cnt_s;

   branch_predictor #(.ENTRIES(16), .WORD_W(32), .CTR_W(2), .MODE(1), .CNT_W(32)) dut (
      .CLK(clk), .RST(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
      .update_target(update_target), .update_pred_taken(update_pred_taken),
      .update_pred_target(update_pred_target), .flush_all(flush_all),
      .mispredict(mispredict), .lookup_cnt(lookup_cnt), .mispredict_cnt(mispredict_cnt)
   );

   branch_predictor #(.ENTRIES(16), .WORD_W(32), .CTR_W(2), .MODE(0), .CNT_W(4)) dut_s (
      .CLK(clk), .RST(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
      .pred_taken(pred_taken_s), .pred_target(pred_target_s),
      .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
      .update_target(update_target), .update_pred_taken(update_pred_taken),
      .update_pred_target(update_pred_target), .flush_all(flush_all),
      .mispredict(mispredict_s), .lookup_cnt(lookup_cnt_s), .mispredict_cnt(mispredict_cnt_s)
   );

   // clock / reset
   always #5 clk = ~clk;

   // behavioural model: entries by index, counters as plain integers
   bit          m_valid [ENT];
   logic [31:0] m_tag   [ENT];
   logic [31:0] m_tgt   [ENT];
   int          m_ctr   [ENT];
   longint      m_lk, m_mp;

   logic [WORD_W-1:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int step_no  = 0;

   function automatic int pc_idx(input logic [31:0] pc);
      return int'((pc / 4) % ENT);
   endfunction

   function automatic logic [31:0] pc_tag(input logic [31:0] pc);
      return pc / (ENT * 4);
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int i;
      i = pc_idx(pc);
      return m_valid[i] && (m_tag[i] == pc_tag(pc));
   endfunction

   function automatic bit model_taken(input logic [31:0] pc);
      return model_hit(pc) && (m_ctr[pc_idx(pc)] >= (CTR_MAX + 1) / 2);
   endfunction

   function automatic logic [31:0] model_target(input logic [31:0] pc);
      return model_taken(pc) ? m_tgt[pc_idx(pc)] : pc + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_lk = 0;
      m_mp = 0;
   endtask

   task automatic model_train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
      int i;
      i = pc_idx(pc);
      if (model_hit(pc)) begin
         if (taken) begin
            m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
            m_tgt[i] = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (taken) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = pc_tag(pc);
         m_tgt[i]   = tgt;
         m_ctr[i]   = (CTR_MAX + 1) / 2;
      end
   endtask

   function automatic longint sat(input longint v, input longint max);
      return (v > max) ? max : v;
   endfunction

   // scoreboard compare
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
      end
   endtask

   // driver: apply one cycle of inputs, check before the edge, advance the model after it
   task automatic step(input bit le, input logic [31:0] lpc,
                       input bit ue, input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                       input bit upt, input logic [31:0] uptg, input bit fl, input bit r);
      bit exp_mp;
      step_no++;
      rst = r; lookup_en = le; lookup_pc = lpc;
      update_en = ue; update_pc = upc; update_taken = ut; update_target = utg;
      update_pred_taken = upt; update_pred_target = uptg; flush_all = fl;
      exp_mp = ue && ((ut != upt) || (ut && (uptg != utg)));
      #1;
      exp_q.push_back(model_target(lpc));
      chk("pred_taken", {63'd0, pred_taken}, {63'd0, model_taken(lpc)});
      chk("pred_target", {32'd0, pred_target}, {32'd0, exp_q.pop_front()});
      chk("mispredict", {63'd0, mispredict}, {63'd0, exp_mp});
      chk("lookup_cnt", {32'd0, lookup_cnt}, 64'(sat(m_lk, 64'hFFFF_FFFF)));
      chk("mispredict_cnt", {32'd0, mispredict_cnt}, 64'(sat(m_mp, 64'hFFFF_FFFF)));
      chk("s_pred_taken", {63'd0, pred_taken_s}, 64'd0);
      chk("s_pred_target", {32'd0, pred_target_s}, {32'd0, lpc + 32'd4});
      chk("s_mispredict", {63'd0, mispredict_s}, {63'd0, exp_mp});
      chk("s_lookup_cnt", {60'd0, lookup_cnt_s}, 64'(sat(m_lk, 15)));
      chk("s_mispredict_cnt", {60'd0, mispredict_cnt_s}, 64'(sat(m_mp, 15)));
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (le) m_lk++;
         if (exp_mp) m_mp++;
         if (fl) begin
            for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
         end else if (ue) begin
            model_train(upc, ut, utg);
         end
      end
      @(negedge clk);
   endtask

   task automatic look(input logic [31:0] pc);
      step(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                      input bit pt, input logic [31:0] ptg);
      step(1'b1, pc, 1'b1, pc, t, tgt, pt, ptg, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] pc, upc, utg, uptg;
      bit ut, upt;

      rst = 1'b1; lookup_en = 1'b0; lookup_pc = '0; update_en = 1'b0; update_pc = '0;
      update_taken = 1'b0; update_target = '0; update_pred_taken = 1'b0;
      update_pred_target = '0; flush_all = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state and first allocation
      look(32'h40);
      chk("tp1_target", {32'd0, pred_target}, 64'h44);
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      look(32'h40);
      chk("tp2_target", {32'd0, pred_target}, 64'h100);

      // hysteresis
      upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      look(32'h40);
      upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      look(32'h40);
      chk("tp3_target", {32'd0, pred_target}, 64'h44);

      // aliasing on index 0
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      look(32'h80);
      upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      look(32'h40);
      look(32'h80);

      // flush with a simultaneous taken update
      step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44, 1'b1, 1'b0);
      look(32'h40);
      look(32'h80);

      // twenty mispredicts on a never-taken branch
      for (int i = 0; i < 20; i++) upd(32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000);
      look(32'h1000);

      // reset mid-operation with a pending update
      upd(32'h40, 1'b1, 32'h500, 1'b0, 32'h44);
      step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h600, 1'b0, 32'h44, 1'b0, 1'b1);
      look(32'h40);

      // randomized traffic over a small PC pool to force hits, aliases and retraining
      for (int n = 0; n < 600; n++) begin
         pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         ut  = ($urandom_range(0, 9) < 6);
         utg = {$urandom_range(0, 7), 2'b00};
         if ($urandom_range(0, 9) < 7) begin
            upt  = model_taken(upc);
            uptg = model_target(upc);
         end else begin
            upt  = $urandom_range(0, 1);
            uptg = {$urandom_range(0, 7), 2'b00};
         end
         step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0, upc, ut, utg, upt, uptg,
              $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
